wav_receiver: RTL and testbench
===============================

Name: wav_receiver

Overview:
- Sink end of the `wav_interface` data stream: accepts DW-bit beats over a valid/ready handshake.
- Checks each beat against an incrementing reference pattern and flags handshake-rule violations.
- Counts accepted beats and reports completion.
- Uses the same `ctl_run` / `sts_end` control convention as the stream source, so one testbench can pair source and sink back to back.

Parameters:
- `DW`, 8, data width of the stream.
- `CW`, 16, width of the accepted-beat counter.
- `RDY_PAT`, 4'b1111, backpressure pattern, rotated LSB-first during RUN; 4'b0101 gives 50% ready.

Ports:
- `clk`  input  1  system clock, all logic on rising edge.
- `rst`  input  1  synchronous reset, active-high.
- `ctl_run`  input  1  run request: level high starts/continues reception, low aborts.
- `rx_vld`  input  1  stream valid.
- `rx_dat`  input  DW  stream data.
- `rx_lst`  input  1  last beat of the stream; qualified by transfer.
- `rx_rdy`  output  1  stream ready.
- `sts_end`  output  1  reception finished (last beat or abort).
- `sts_err`  output  2  sticky errors: [0] data mismatch, [1] protocol violation.
- `sts_cnt`  output  CW  accepted-beat count.

Behaviour:
- Reset values: state IDLE, `rx_rdy`=0, `sts_end`=0, `sts_err`=0, `sts_cnt`=0, expected value `exp`=0, pattern pointer `ptr`=0.
- `rx_rdy` is decoded from registered state and `ptr` only; it has no combinational path from any input.
- Transfer: a cycle with `rx_vld`=1 and `rx_rdy`=1.
- State IDLE:
  - `rx_rdy`=0.
  - When `ctl_run`=1 is sampled: go to RUN and clear `sts_end`, `sts_err`, `sts_cnt`, `exp`, `ptr`.
  - Status values from the previous run are held in IDLE until that next start.
- State RUN:
  - `rx_rdy` = `RDY_PAT[ptr]`; `ptr` increments every cycle, wrapping 3 -> 0.
  - The first RUN cycle uses `RDY_PAT[0]`.
- On each transfer in RUN:
  - If `rx_dat` != `exp`, set `sts_err[0]`.
  - `exp` <= `rx_dat`+1, modulo 2^DW: resynchronise, so one bad beat flags once.
  - `exp` wraps (2^DW-1) -> 0 with no error.
  - `sts_cnt` increments, saturating at 2^CW-1.
- Protocol check, active in RUN only:
  - If the previous cycle had `rx_vld`=1 and `rx_rdy`=0, then the current cycle must have `rx_vld`=1 with `rx_dat` and `rx_lst` unchanged.
  - Otherwise set `sts_err[1]`.
  - The check state is cleared on entry to RUN.
- RUN -> DONE on either:
  - a transfer with `rx_lst`=1, or
  - `ctl_run`=0 (abort).
- Simultaneous last-beat transfer and `ctl_run`=0: the beat is accepted, checked and counted, then DONE.
- An abort cycle with `rx_vld`=1 and `rx_rdy`=1 still counts as a transfer.
- State DONE:
  - `rx_rdy`=0, `sts_end`=1.
  - Go to IDLE when `ctl_run`=0. `sts_end` stays 1 in IDLE until the next start.
  - If `ctl_run` stays 1 in DONE, remain in DONE; no auto-restart.
- Error bits are sticky within a run and never cleared by the stream.
- Reset mid-run: everything returns to reset values on the next edge, and any in-flight beat is dropped.
- Latency: `sts_end` rises on the edge following the last transfer, or one edge after `ctl_run` falls.

Test Plan:
- Nominal: `RDY_PAT`=4'b1111; source sends 0..15 with `rx_lst` on 15, `ctl_run` held high -> `rx_rdy`=1 every RUN cycle, `sts_cnt`=16, `sts_err`=2'b00, `sts_end`=1 one cycle after beat 15.
- Backpressure: `RDY_PAT`=4'b0101, compliant source, 8 beats -> transfers only on even `ptr` cycles, `sts_cnt`=8, `sts_err`=2'b00.
- Data error and wrap:
  - DW=8, stream 254,255,0,1 -> no error.
  - Stream 0,1,5,6 -> `sts_err[0]`=1 exactly once, `sts_cnt`=4.
- Protocol violation: source drops `rx_vld` while `rx_rdy`=0, or changes `rx_dat` from 3 to 4 while stalled -> `sts_err[1]`=1.
- Abort and restart:
  - Drop `ctl_run` after 5 transfers with no `rx_lst` -> DONE, `sts_end`=1, `sts_cnt`=5.
  - Raise `ctl_run` again -> `sts_cnt`/`sts_err`/`sts_end` cleared, `exp`=0.
  - `rx_lst` transfer in the same cycle `ctl_run` falls -> counted, `sts_end`=1.
- Reset mid-run: assert `rst` for 1 cycle after 3 beats -> next cycle `rx_rdy`=0, `sts_cnt`=0, `sts_err`=0, `sts_end`=0, state IDLE.

Source files
------------

// File: rtl/wav_receiver.sv
// wav_receiver: sink end of the wav_interface stream.
// Accepts DW-bit beats over valid/ready, checks them against an incrementing
// reference, flags handshake-rule violations and counts accepted beats.
// Control follows the ctl_run / sts_end convention shared with the source.
module wav_receiver #(
    parameter int          DW      = 8,
    parameter int          CW      = 16,
    parameter logic [3:0]  RDY_PAT = 4'b1111
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ctl_run_i,
    input  logic          rx_vld_i,
    input  logic [DW-1:0] rx_dat_i,
    input  logic          rx_lst_i,
    output logic          rx_rdy_o,
    output logic          sts_end_o,
    output logic [1:0]    sts_err_o,
    output logic [CW-1:0] sts_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [1:0]    ptr_q;
    logic [DW-1:0] exp_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    err_q;
    logic          end_q;

    // Snapshot of a stalled beat (valid seen while not ready) for the
    // hold-stable protocol check on the following cycle.
    logic          hold_q;
    logic [DW-1:0] hold_dat_q;
    logic          hold_lst_q;

    logic xfer;
    logic hold_broken;

    // Ready depends only on registered state and pointer, never on inputs.
    assign rx_rdy_o = (state_q == S_RUN) && RDY_PAT[ptr_q];

    // Transfer and protocol-check qualifiers for the current cycle.
    always_comb begin
        xfer        = 1'b0;
        hold_broken = 1'b0;
        if (state_q == S_RUN) begin
            xfer        = rx_vld_i && rx_rdy_o;
            hold_broken = hold_q && (!rx_vld_i
                                     || (rx_dat_i != hold_dat_q)
                                     || (rx_lst_i != hold_lst_q));
        end
    end

    // Control FSM with all status registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            ptr_q      <= 2'd0;
            exp_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 2'b00;
            end_q      <= 1'b0;
            hold_q     <= 1'b0;
            hold_dat_q <= '0;
            hold_lst_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    hold_q <= 1'b0;
                    // Previous run's status stays visible until the next start.
                    if (ctl_run_i) begin
                        state_q <= S_RUN;
                        ptr_q   <= 2'd0;
                        exp_q   <= '0;
                        cnt_q   <= '0;
                        err_q   <= 2'b00;
                        end_q   <= 1'b0;
                    end
                end

                S_RUN: begin
                    ptr_q <= ptr_q + 2'd1;

                    // Remember a stalled beat; anything else releases the check.
                    hold_q     <= rx_vld_i && !rx_rdy_o;
                    hold_dat_q <= rx_dat_i;
                    hold_lst_q <= rx_lst_i;

                    if (hold_broken)
                        err_q[1] <= 1'b1;

                    if (xfer) begin
                        if (rx_dat_i != exp_q)
                            err_q[0] <= 1'b1;
                        // Resynchronise on the received value so a single bad
                        // beat flags once instead of poisoning the rest.
                        exp_q <= rx_dat_i + DW'(1);
                        if (cnt_q != {CW{1'b1}})
                            cnt_q <= cnt_q + CW'(1);
                    end

                    // Abort still lets a same-cycle beat be accepted above.
                    if ((xfer && rx_lst_i) || !ctl_run_i) begin
                        state_q <= S_DONE;
                        end_q   <= 1'b1;
                    end
                end

                S_DONE: begin
                    hold_q <= 1'b0;
                    // No auto-restart: run must drop before a new start.
                    if (!ctl_run_i)
                        state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                    hold_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sts_end_o = end_q;
    assign sts_err_o = err_q;
    assign sts_cnt_o = cnt_q;

endmodule

// File: tb/tb_wav_receiver.sv
// Directed bench for wav_receiver: a full-ready instance driven from a vector
// table, and a 50%-ready instance driven by hand-written stall sequences.
module tb_wav_receiver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Full-ready instance (RDY_PAT = 1111)
    logic        f_run = 1'b0, f_vld = 1'b0, f_lst = 1'b0;
    logic [7:0]  f_dat = '0;
    logic        f_rdy, f_end;
    logic [1:0]  f_err;
    logic [15:0] f_cnt;

    // Backpressure instance (RDY_PAT = 0101)
    logic        b_run = 1'b0, b_vld = 1'b0, b_lst = 1'b0;
    logic [7:0]  b_dat = '0;
    logic        b_rdy, b_end;
    logic [1:0]  b_err;
    logic [15:0] b_cnt;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    wav_receiver #(.DW(8), .CW(16), .RDY_PAT(4'b1111)) u_full (
        .clk_i(clk), .rst_i(rst), .ctl_run_i(f_run), .rx_vld_i(f_vld),
        .rx_dat_i(f_dat), .rx_lst_i(f_lst), .rx_rdy_o(f_rdy),
        .sts_end_o(f_end), .sts_err_o(f_err), .sts_cnt_o(f_cnt));

    wav_receiver #(.DW(8), .CW(16), .RDY_PAT(4'b0101)) u_bp (
        .clk_i(clk), .rst_i(rst), .ctl_run_i(b_run), .rx_vld_i(b_vld),
        .rx_dat_i(b_dat), .rx_lst_i(b_lst), .rx_rdy_o(b_rdy),
        .sts_end_o(b_end), .sts_err_o(b_err), .sts_cnt_o(b_cnt));

    typedef struct {
        logic        run;
        logic        vld;
        logic [7:0]  dat;
        logic        lst;
        logic        e_rdy;
        logic        e_end;
        logic [1:0]  e_err;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic run, input logic vld, input int dat,
                       input logic lst, input logic e_rdy, input logic e_end,
                       input int e_err, input int e_cnt);
        vec_t v;
        v.run = run; v.vld = vld; v.dat = 8'(dat); v.lst = lst;
        v.e_rdy = e_rdy; v.e_end = e_end; v.e_err = 2'(e_err);
        v.e_cnt = 16'(e_cnt);
        tbl.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One backpressure cycle: drive a beat, check ready against its phase.
    task automatic bp_cycle(input string name, input logic vld, input int dat,
                            input logic lst, input logic e_rdy);
        chk(name, int'(b_rdy), int'(e_rdy));
        b_vld = vld; b_dat = 8'(dat); b_lst = lst;
        tick();
    endtask

    initial begin
        int beat;
        int k;

        // ---------------- reset state ----------------
        rst = 1'b1;
        tick(); tick();
        chk("rst_rdy", int'(f_rdy), 0);
        chk("rst_end", int'(f_end), 0);
        chk("rst_err", int'(f_err), 0);
        chk("rst_cnt", int'(f_cnt), 0);
        chk("rst_bp_rdy", int'(b_rdy), 0);
        rst = 1'b0;

        // ---------------- table: full-ready instance ----------------
        //   run vld dat lst | rdy end err cnt   (values after the edge)
        add(0, 0, 0, 0,   0, 0, 0, 0);               // idle
        add(1, 0, 0, 0,   1, 0, 0, 0);               // start
        for (int i = 0; i < 16; i++)                 // nominal 0..15
            add(1, 1, i, i == 15, i < 15, i == 15, 0, i + 1);
        add(1, 0, 0, 0,   0, 1, 0, 16);              // DONE holds with run high
        add(0, 0, 0, 0,   0, 1, 0, 16);              // IDLE keeps status
        add(1, 0, 0, 0,   1, 0, 0, 0);               // restart clears
        add(1, 1, 0, 0,   1, 0, 0, 1);               // 0,1,5,6
        add(1, 1, 1, 0,   1, 0, 0, 2);
        add(1, 1, 5, 0,   1, 0, 1, 3);               // mismatch
        add(1, 1, 6, 1,   0, 1, 1, 4);               // resynced, no new flag
        add(0, 0, 0, 0,   0, 1, 1, 4);
        add(1, 0, 0, 0,   1, 0, 0, 0);               // err cleared on start
        add(1, 1, 0, 0,   1, 0, 0, 1);
        add(1, 1, 1, 0,   1, 0, 0, 2);
        add(1, 1, 2, 0,   1, 0, 0, 3);
        add(1, 1, 9, 0,   1, 0, 1, 4);
        add(1, 1, 10, 0,  1, 0, 1, 5);
        add(0, 0, 0, 0,   0, 1, 1, 5);               // abort after 5
        add(0, 0, 0, 0,   0, 1, 1, 5);               // IDLE, held
        add(1, 0, 0, 0,   1, 0, 0, 0);               // restart clears all
        add(1, 1, 0, 0,   1, 0, 0, 1);               // exp back to 0
        add(0, 1, 1, 1,   0, 1, 0, 2);               // last beat + abort
        add(0, 0, 0, 0,   0, 1, 0, 2);
        add(1, 0, 0, 0,   1, 0, 0, 0);
        add(0, 1, 0, 0,   0, 1, 0, 1);               // abort beat still counts
        add(0, 0, 0, 0,   0, 1, 0, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            f_run = tbl[i].run; f_vld = tbl[i].vld;
            f_dat = tbl[i].dat; f_lst = tbl[i].lst;
            tick();
            chk($sformatf("v%0d_rdy", i), int'(f_rdy), int'(tbl[i].e_rdy));
            chk($sformatf("v%0d_end", i), int'(f_end), int'(tbl[i].e_end));
            chk($sformatf("v%0d_err", i), int'(f_err), int'(tbl[i].e_err));
            chk($sformatf("v%0d_cnt", i), int'(f_cnt), int'(tbl[i].e_cnt));
        end

        // ---------------- data wrap: 0..255,0,1 ----------------
        f_run = 1'b1; f_vld = 1'b0; f_lst = 1'b0;
        tick();
        for (int i = 0; i < 258; i++) begin
            f_vld = 1'b1; f_dat = 8'(i); f_lst = (i == 257);
            tick();
        end
        f_vld = 1'b0; f_lst = 1'b0; f_run = 1'b0;
        chk("wrap_err", int'(f_err), 0);
        chk("wrap_cnt", int'(f_cnt), 258);
        chk("wrap_end", int'(f_end), 1);
        tick();

        // ---------------- reset mid-run ----------------
        f_run = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            f_vld = 1'b1; f_dat = 8'(i); f_lst = 1'b0;
            tick();
        end
        chk("pre_rst_cnt", int'(f_cnt), 3);
        rst = 1'b1; f_dat = 8'd3;                    // beat 3 in flight
        tick();
        chk("mrst_rdy", int'(f_rdy), 0);
        chk("mrst_cnt", int'(f_cnt), 0);
        chk("mrst_err", int'(f_err), 0);
        chk("mrst_end", int'(f_end), 0);
        rst = 1'b0; f_run = 1'b0; f_vld = 1'b0;
        tick();
        chk("mrst_idle_rdy", int'(f_rdy), 0);
        chk("mrst_idle_cnt", int'(f_cnt), 0);

        // ---------------- backpressure, compliant source ----------------
        b_run = 1'b1;
        tick();
        beat = 0;
        k = 0;
        while (beat < 8 && k < 40) begin
            logic er;
            er = (k % 2) == 0;
            bp_cycle($sformatf("bp_rdy_k%0d", k), 1'b1, beat, beat == 7, er);
            if (er) beat++;
            k++;
        end
        chk("bp_budget", k, 15);
        b_vld = 1'b0; b_lst = 1'b0;
        chk("bp_cnt", int'(b_cnt), 8);
        chk("bp_err", int'(b_err), 0);
        chk("bp_end", int'(b_end), 1);
        chk("bp_done_rdy", int'(b_rdy), 0);
        b_run = 1'b0;
        tick();

        // ---------------- protocol: valid dropped while stalled ----------------
        b_run = 1'b1;
        tick();
        bp_cycle("pv1_c0", 1'b0, 0, 1'b0, 1'b1);
        bp_cycle("pv1_c1", 1'b1, 0, 1'b0, 1'b0);    // stall
        chk("pv1_err_before", int'(b_err), 0);
        bp_cycle("pv1_c2", 1'b0, 0, 1'b0, 1'b1);    // valid withdrawn
        chk("pv1_err", int'(b_err), 2);
        chk("pv1_cnt", int'(b_cnt), 0);
        b_run = 1'b0; b_vld = 1'b0;
        tick();
        chk("pv1_abort_end", int'(b_end), 1);
        tick();

        // ---------------- protocol: data changes 3 -> 4 while stalled ----------------
        b_run = 1'b1;
        tick();
        chk("pv2_start_err", int'(b_err), 0);
        bp_cycle("pv2_c0", 1'b1, 0, 1'b0, 1'b1);
        bp_cycle("pv2_c1", 1'b1, 1, 1'b0, 1'b0);
        bp_cycle("pv2_c2", 1'b1, 1, 1'b0, 1'b1);
        bp_cycle("pv2_c3", 1'b1, 2, 1'b0, 1'b0);
        bp_cycle("pv2_c4", 1'b1, 2, 1'b0, 1'b1);
        bp_cycle("pv2_c5", 1'b1, 3, 1'b0, 1'b0);    // stalled on 3
        chk("pv2_err_before", int'(b_err), 0);
        chk("pv2_cnt_before", int'(b_cnt), 3);
        bp_cycle("pv2_c6", 1'b1, 4, 1'b0, 1'b1);    // changed to 4, accepted
        chk("pv2_err", int'(b_err), 3);
        chk("pv2_cnt", int'(b_cnt), 4);
        b_run = 1'b0; b_vld = 1'b0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
